// File: rtl/branch_ctrl_if.sv
// Request/response bundle between the main controller FSM, the zero-flag
// register and branch_ctrl. The master side is the controller/flag register;
// the slave side is branch_ctrl.
interface branch_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned CNT_W = 16;

  logic              pc_inc;
  logic              br_req;
  logic [1:0]        br_type;
  logic [ADDR_W-1:0] br_target;
  logic              z_in;
  logic              z_rd_en;
  logic [ADDR_W-1:0] pc;
  logic              br_busy;
  logic              br_done;
  logic              br_taken;
  logic [CNT_W-1:0]  br_cnt;

  modport master (
    output pc_inc, br_req, br_type, br_target, z_in,
    input  z_rd_en, pc, br_busy, br_done, br_taken, br_cnt
  );

  modport slave (
    input  pc_inc, br_req, br_type, br_target, z_in,
    output z_rd_en, pc, br_busy, br_done, br_taken, br_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// Program counter and conditional-branch sequencer. Owns the zero-flag
// register output-enable, reads the flag and resolves JMP/JMPZ/JMPNZ.
// Optional feature macro: BR_TAKEN_CNT_EN builds a saturating 16-bit
// taken-branch counter on br_cnt; without it br_cnt is tied to zero.
module branch_ctrl #(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          RST,
  branch_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] BR_JMP   = 2'b00;
  localparam logic [1:0] BR_JMPZ  = 2'b01;
  localparam logic [1:0] BR_JMPNZ = 2'b10;
  localparam logic [1:0] BR_RSV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RDZ  = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              jnz_q, jnz_d;
  logic              z_rd_en_q, z_rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              taken_q, taken_d;

  // State and output registers; reset aborts any branch in flight.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pc_q      <= RST_ADDR;
      tgt_q     <= '0;
      jnz_q     <= 1'b0;
      z_rd_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      jnz_q     <= jnz_d;
      z_rd_en_q <= z_rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
    end
  end

  // Next-state, PC update and branch resolution.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    jnz_d     = jnz_q;
    z_rd_en_d = 1'b0;
    done_d    = 1'b0;
    taken_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.br_req) begin
          case (bus.br_type)
            BR_JMP: begin
              pc_d    = bus.br_target;
              done_d  = 1'b1;
              taken_d = 1'b1;
            end
            BR_RSV: begin
              pc_d   = pc_q + ADDR_W'(1);
              done_d = 1'b1;
            end
            default: begin
              tgt_d     = bus.br_target;
              jnz_d     = (bus.br_type == BR_JMPNZ);
              z_rd_en_d = 1'b1;
              state_d   = RDZ;
            end
          endcase
        end else if (bus.pc_inc) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      RDZ: begin
        state_d = EVAL;
      end
      EVAL: begin
        // JMPZ takes on z=1, JMPNZ on z=0.
        taken_d = bus.z_in ^ jnz_q;
        pc_d    = taken_d ? tgt_q : pc_q + ADDR_W'(1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef BR_TAKEN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of taken branches, aligned with the br_done pulse.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (done_d && taken_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.br_cnt = cnt_q;
`else
  assign bus.br_cnt = CNT_W'(0);
`endif

  assign bus.pc       = pc_q;
  assign bus.z_rd_en  = z_rd_en_q;
  assign bus.br_busy  = busy_q;
  assign bus.br_done  = done_q;
  assign bus.br_taken = taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a cycle-scheduled reference model.
module tb_branch_ctrl;
  localparam int unsigned ADDR_W   = 8;
  localparam logic [7:0]  RST_ADDR = 8'h10;
`ifdef BR_TAKEN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  branch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  branch_ctrl #(.ADDR_W(ADDR_W), .RST_ADDR(RST_ADDR)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a conditional branch accepted at cycle k is scheduled to
  // resolve at the edge ending cycle k+2; the flag read occurs in cycle k+1.
  int          cyc = 0;
  int          resolve_at = -1;
  logic [7:0]  m_pc = RST_ADDR;
  logic [7:0]  m_tgt = '0;
  logic [1:0]  m_type = '0;
  logic        m_done = 1'b0;
  logic        m_taken = 1'b0;
  logic [15:0] m_cnt = '0;

  function automatic logic cond_taken(input logic [1:0] ty, input logic z);
    return (ty == 2'b01 && z) || (ty == 2'b10 && !z);
  endfunction

  function automatic logic [15:0] bump(input logic [15:0] c);
    return (CNT_EN && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      m_pc       <= RST_ADDR;
      m_done     <= 1'b0;
      m_taken    <= 1'b0;
      m_cnt      <= '0;
      resolve_at <= -1;
    end else begin
      m_done  <= 1'b0;
      m_taken <= 1'b0;
      cyc     <= cyc + 1;
      if (resolve_at == cyc) begin
        m_done     <= 1'b1;
        m_taken    <= cond_taken(m_type, bus.z_in);
        m_pc       <= cond_taken(m_type, bus.z_in) ? m_tgt : m_pc + 8'd1;
        if (cond_taken(m_type, bus.z_in)) m_cnt <= bump(m_cnt);
        resolve_at <= -1;
      end else if (resolve_at < 0) begin
        if (bus.br_req) begin
          if (bus.br_type == 2'b00) begin
            m_pc    <= bus.br_target;
            m_done  <= 1'b1;
            m_taken <= 1'b1;
            m_cnt   <= bump(m_cnt);
          end else if (bus.br_type == 2'b11) begin
            m_pc   <= m_pc + 8'd1;
            m_done <= 1'b1;
          end else begin
            m_type     <= bus.br_type;
            m_tgt      <= bus.br_target;
            resolve_at <= cyc + 2;
          end
        end else if (bus.pc_inc) begin
          m_pc <= m_pc + 8'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_pc", 32'(bus.pc), 32'(m_pc));
      chk("cyc_z_rd_en", 32'(bus.z_rd_en), 32'(resolve_at >= 0 && resolve_at == cyc + 1));
      chk("cyc_busy", 32'(bus.br_busy), 32'(resolve_at >= 0));
      chk("cyc_done", 32'(bus.br_done), 32'(m_done));
      if (m_done) chk("cyc_taken", 32'(bus.br_taken), 32'(m_taken));
      chk("cyc_cnt", 32'(bus.br_cnt), 32'(m_cnt));
    end
  end

  task automatic drive(input logic req, input logic [1:0] ty, input logic [7:0] tg, input logic inc);
    bus.br_req    = req;
    bus.br_type   = ty;
    bus.br_target = tg;
    bus.pc_inc    = inc;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 8'h00, 1'b0);
  endtask

  initial begin
    RST           = 1'b0;
    bus.br_req    = 1'b0;
    bus.br_type   = 2'b00;
    bus.br_target = 8'h00;
    bus.pc_inc    = 1'b0;
    bus.z_in      = 1'b0;
    #1 started = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 32'h10);
    chk("rst_flags", {28'd0, bus.z_rd_en, bus.br_busy, bus.br_done, bus.br_taken}, 32'h0);
    chk("rst_cnt", 32'(bus.br_cnt), 32'h0);
    RST = 1'b1;

    // three increments
    repeat (3) drive(1'b0, 2'b00, 8'h00, 1'b1);
    chk("inc3_pc", 32'(bus.pc), 32'h13);

    // wrap FF -> 00
    drive(1'b1, 2'b00, 8'hFF, 1'b0);
    chk("jmp_ff_pc", 32'(bus.pc), 32'hFF);
    chk("jmp_ff_done", {30'd0, bus.br_done, bus.br_taken}, 32'h3);
    drive(1'b0, 2'b00, 8'h00, 1'b1);
    chk("wrap_pc", 32'(bus.pc), 32'h00);

    // JMPZ taken
    drive(1'b1, 2'b00, 8'h05, 1'b0);
    bus.z_in = 1'b1;
    drive(1'b1, 2'b01, 8'h40, 1'b0);
    chk("jz_n1_rd_busy", {30'd0, bus.z_rd_en, bus.br_busy}, 32'h3);
    idle();
    chk("jz_n2_rd_busy", {30'd0, bus.z_rd_en, bus.br_busy}, 32'h1);
    chk("jz_n2_pc", 32'(bus.pc), 32'h05);
    idle();
    chk("jz_n3_pc", 32'(bus.pc), 32'h40);
    chk("jz_n3_done_taken", {29'd0, bus.br_busy, bus.br_done, bus.br_taken}, 32'h3);

    // JMPNZ with z=1 (not taken), back-to-back after JMP
    drive(1'b1, 2'b00, 8'h05, 1'b0);
    drive(1'b1, 2'b10, 8'h40, 1'b0);
    idle();
    idle();
    chk("jnz_z1_pc", 32'(bus.pc), 32'h06);
    chk("jnz_z1_done_taken", {30'd0, bus.br_done, bus.br_taken}, 32'h2);

    // JMPNZ with z=0 (taken)
    bus.z_in = 1'b0;
    drive(1'b1, 2'b00, 8'h05, 1'b0);
    drive(1'b1, 2'b10, 8'h40, 1'b0);
    idle();
    idle();
    chk("jnz_z0_pc", 32'(bus.pc), 32'h40);
    chk("jnz_z0_taken", 32'(bus.br_taken), 32'h1);

    // JMP with simultaneous pc_inc
    drive(1'b1, 2'b00, 8'h22, 1'b1);
    chk("jmp_inc_pc", 32'(bus.pc), 32'h22);
    chk("jmp_inc_rd", 32'(bus.z_rd_en), 32'h0);

    // reserved type
    drive(1'b1, 2'b11, 8'h99, 1'b0);
    chk("rsv_pc", 32'(bus.pc), 32'h23);
    chk("rsv_done_taken", {30'd0, bus.br_done, bus.br_taken}, 32'h2);

    // requests during RDZ/EVAL are ignored
    drive(1'b1, 2'b01, 8'h50, 1'b0);
    drive(1'b1, 2'b00, 8'h77, 1'b1);
    drive(1'b1, 2'b00, 8'h77, 1'b1);
    chk("ign_pc", 32'(bus.pc), 32'h24);
    chk("ign_done_taken", {30'd0, bus.br_done, bus.br_taken}, 32'h2);
    idle();
    chk("ign_pc_after", 32'(bus.pc), 32'h24);

    // reset during EVAL
    drive(1'b1, 2'b01, 8'h60, 1'b0);
    idle();
    #1 RST = 1'b0;
    #1;
    chk("midrst_pc", 32'(bus.pc), 32'h10);
    chk("midrst_rd_busy", {30'd0, bus.z_rd_en, bus.br_busy}, 32'h0);
    @(negedge clk);
    RST = 1'b1;
    repeat (3) idle();
    chk("midrst_no_done", 32'(bus.br_done), 32'h0);
    chk("midrst_pc_after", 32'(bus.pc), 32'h10);

    // taken counter: 2 taken JMPZ + 1 JMP + 1 not-taken JMPNZ
    bus.z_in = 1'b1;
    drive(1'b1, 2'b01, 8'h30, 1'b0);
    idle();
    idle();
    drive(1'b1, 2'b01, 8'h31, 1'b0);
    idle();
    idle();
    drive(1'b1, 2'b00, 8'h08, 1'b0);
    drive(1'b1, 2'b10, 8'h09, 1'b0);
    idle();
    idle();
    idle();
    chk("cnt_pc", 32'(bus.pc), 32'h09);
    chk("cnt_value", 32'(bus.br_cnt), CNT_EN ? 32'd3 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
